// File: rtl/buffer_m1_addr_gen.sv
// Mode-1 read/write address and enable sequencer for the buffer bank.
// Reads stream from rd_base; writes trail them by PIPE_LAT unstalled cycles.
module buffer_m1_addr_gen #(
   parameter int N_BUF    = 8,
   parameter int ADDR_W   = 10,
   parameter int LEN_W    = 11,
   parameter int PIPE_LAT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [N_BUF-1:0]        rd_mask,
   input  logic [N_BUF-1:0]        wr_mask,
   input  logic [ADDR_W-1:0]       rd_base,
   input  logic [ADDR_W-1:0]       wr_base,
   input  logic [ADDR_W-1:0]       stride,
   input  logic [LEN_W-1:0]        len,
   input  logic                    stall,
   output logic [N_BUF-1:0]        m1_r_en,
   output logic [N_BUF*ADDR_W-1:0] m1_r_addr,
   output logic [N_BUF-1:0]        m1_w_en,
   output logic [N_BUF*ADDR_W-1:0] m1_w_addr,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t state, state_n;

   logic [N_BUF-1:0]    rd_mask_q, wr_mask_q, rd_mask_eff;
   logic [ADDR_W-1:0]   stride_q, rd_ptr, wr_ptr, rd_addr_eff;
   logic [LEN_W-1:0]    len_q, rd_cnt, wr_cnt;
   logic [PIPE_LAT-1:0] vld, vld_n;
   logic                go, step, rd_issue, wr_issue;

   always_comb begin
      go          = (state == IDLE) && start;
      step        = ((state == READ) || (state == DRAIN)) && !stall;
      rd_issue    = go ? (len != '0) : (step && (state == READ));
      wr_issue    = step && vld[PIPE_LAT-1];
      rd_mask_eff = go ? rd_mask : rd_mask_q;
      rd_addr_eff = go ? rd_base : rd_ptr;
      vld_n       = vld << 1;
      vld_n[0]    = rd_issue;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (len == '0)                 state_n = DONE;
               else if (len == LEN_W'(1))     state_n = DRAIN;
               else                           state_n = READ;
            end
         end
         READ: begin
            if (step && (rd_cnt + LEN_W'(1) == len_q)) state_n = DRAIN;
         end
         DRAIN: begin
            if (wr_cnt == len_q) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_mask_q <= '0;
         wr_mask_q <= '0;
         stride_q  <= '0;
         len_q     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         vld       <= '0;
         m1_r_en   <= '0;
         m1_r_addr <= '0;
         m1_w_en   <= '0;
         m1_w_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (go) begin
            rd_mask_q <= rd_mask;
            wr_mask_q <= wr_mask;
            stride_q  <= stride;
            len_q     <= len;
            rd_ptr    <= rd_base + stride;
            wr_ptr    <= wr_base;
            rd_cnt    <= (len != '0) ? LEN_W'(1) : '0;
            wr_cnt    <= '0;
         end
         if (go || step) vld <= vld_n;
         if (step && (state == READ)) begin
            rd_ptr <= rd_ptr + stride_q;
            rd_cnt <= rd_cnt + LEN_W'(1);
         end
         if (wr_issue) begin
            wr_ptr <= wr_ptr + stride_q;
            wr_cnt <= wr_cnt + LEN_W'(1);
         end
         m1_r_en <= rd_issue ? rd_mask_eff : '0;
         m1_w_en <= wr_issue ? wr_mask_q : '0;
         // inactive buffers keep their last address
         for (int i = 0; i < N_BUF; i++) begin
            if (rd_issue && rd_mask_eff[i])
               m1_r_addr[i*ADDR_W +: ADDR_W] <= rd_addr_eff;
            if (wr_issue && wr_mask_q[i])
               m1_w_addr[i*ADDR_W +: ADDR_W] <= wr_ptr;
         end
         busy <= (state_n == READ) || (state_n == DRAIN);
         done <= (state_n == DONE);
      end
   end

endmodule
